// File: rtl/gvp_stream_packer.sv
// rtl/gvp_stream_packer.sv - snapshot GVP store ticks into tagged frames on an AXI4-Stream master
//
// Optional feature macro: GVP_PACK_TIMESTAMP_EN (inserts a 64-bit a_clk timestamp after the tag).
//
// Ports:
//   a_clk, reset            clock and asynchronous active-high reset
//   enable, sample_tick     capture enable and one-cycle GVP step pulse
//   store_data              2 = header frame, 1 = data frame, 0/3 = no capture
//   gvp_finished            end-of-program flag, suppresses repeated header frames
//   x, y, z, u              vector position
//   options, section        section options and section count
//   src0..src3              data-source words
//   M_AXIS_*                AXI4-Stream master (tdata/tvalid/tlast/tready)
//   busy                    serializer active or snapshot buffer full
//   overflow_count          saturating count of dropped captures
//   frames_sent             count of completed frames

module gvp_stream_packer #(
    parameter int SEQ_W = 8,
    parameter int OVF_W = 16
) (
    input  logic             a_clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             sample_tick,
    input  logic [1:0]       store_data,
    input  logic             gvp_finished,
    input  logic [31:0]      x,
    input  logic [31:0]      y,
    input  logic [31:0]      z,
    input  logic [31:0]      u,
    input  logic [31:0]      options,
    input  logic [31:0]      section,
    input  logic [31:0]      src0,
    input  logic [31:0]      src1,
    input  logic [31:0]      src2,
    input  logic [31:0]      src3,
    output logic [31:0]      M_AXIS_tdata,
    output logic             M_AXIS_tvalid,
    output logic             M_AXIS_tlast,
    input  logic             M_AXIS_tready,
    output logic             busy,
    output logic [OVF_W-1:0] overflow_count,
    output logic [31:0]      frames_sent
);

`ifdef GVP_PACK_TIMESTAMP_EN
    localparam int   TS_WORDS = 2;
    localparam logic TS_BIT   = 1'b1;
`else
    localparam int   TS_WORDS = 0;
    localparam logic TS_BIT   = 1'b0;
`endif

    // Longest frame is the data frame.
    localparam int MAXW = 9 + TS_WORDS;

    typedef enum logic {IDLE, SEND} state_t;

    state_t state;

    // Snapshot buffer
    logic             buf_full;
    logic             buf_hdr;
    logic [SEQ_W-1:0] buf_seq;
    logic [31:0]      buf_x, buf_y, buf_z, buf_u;
    logic [31:0]      buf_options, buf_section;
    logic [31:0]      buf_src [4];
    logic [SEQ_W-1:0] seq;

    // Finished suppression
    logic fin_prev;
    logic fin_arm;
    logic fin_block;

    // Serializer: tdata holds the current word, frm the words still to come.
    logic [31:0] frm [MAXW];
    logic [3:0]  rem;

    logic        capture;
    logic        hs;
    logic        last_hs;
    logic        xfer;
    logic        buf_free;
    logic        accept;
    logic        drop;
    logic [31:0] nxt_w [MAXW];
    logic [3:0]  nxt_len;
    logic [7:0]  seq8;

`ifdef GVP_PACK_TIMESTAMP_EN
    logic [63:0] ts_cnt;
    logic [63:0] buf_ts;

    always_ff @(posedge a_clk or posedge reset) begin
        if (reset) begin
            ts_cnt <= '0;
            buf_ts <= '0;
        end else begin
            ts_cnt <= ts_cnt + 64'd1;
            if (accept) begin
                buf_ts <= ts_cnt;
            end
        end
    end
`endif

    assign capture  = sample_tick && enable && (store_data == 2'd1 || store_data == 2'd2) && !fin_block;
    assign hs       = M_AXIS_tvalid && M_AXIS_tready;
    assign last_hs  = hs && M_AXIS_tlast;
    // The buffer moves into the serializer when idle or exactly on the last
    // handshake of the current frame, which gives back-to-back frames no bubble.
    assign xfer     = buf_full && (state == IDLE || last_hs);
    // A buffer being emptied this cycle may be refilled in the same cycle.
    assign buf_free = !buf_full || xfer;
    assign accept   = capture && buf_free;
    assign drop     = capture && !buf_free;
    assign busy     = (state == SEND) || buf_full;
    assign seq8     = 8'(buf_seq);

    always_ff @(posedge a_clk or posedge reset) begin
        if (reset) begin
            buf_full       <= 1'b0;
            buf_hdr        <= 1'b0;
            buf_seq        <= '0;
            buf_x          <= '0;
            buf_y          <= '0;
            buf_z          <= '0;
            buf_u          <= '0;
            buf_options    <= '0;
            buf_section    <= '0;
            for (int i = 0; i < 4; i++) begin
                buf_src[i] <= '0;
            end
            seq            <= '0;
            overflow_count <= '0;
            fin_prev       <= 1'b0;
            fin_arm        <= 1'b0;
            fin_block      <= 1'b0;
        end else begin
            if (accept) begin
                buf_full    <= 1'b1;
                buf_hdr     <= (store_data == 2'd2);
                buf_seq     <= seq;
                buf_x       <= x;
                buf_y       <= y;
                buf_z       <= z;
                buf_u       <= u;
                buf_options <= options;
                buf_section <= section;
                buf_src[0]  <= src0;
                buf_src[1]  <= src1;
                buf_src[2]  <= src2;
                buf_src[3]  <= src3;
                seq         <= seq + 1'b1;
            end else if (xfer) begin
                buf_full <= 1'b0;
            end

            if (drop && overflow_count != {OVF_W{1'b1}}) begin
                overflow_count <= overflow_count + 1'b1;
            end

            // The first header after gvp_finished rises is the final one;
            // later headers are blocked until gvp_finished drops.
            fin_prev <= gvp_finished;
            if (!gvp_finished && fin_prev) begin
                fin_block <= 1'b0;
            end
            if (capture && store_data == 2'd2 && fin_arm) begin
                fin_block <= 1'b1;
                fin_arm   <= 1'b0;
            end
            if (gvp_finished && !fin_prev) begin
                fin_arm <= 1'b1;
            end
        end
    end

    // Frame assembly from the snapshot buffer.
    always_comb begin
        for (int i = 0; i < MAXW; i++) begin
            nxt_w[i] = '0;
        end
        nxt_len  = '0;
        nxt_w[0] = {4'hA, (buf_hdr ? 2'b10 : 2'b01), 1'b0, TS_BIT, seq8, buf_section[15:0]};
`ifdef GVP_PACK_TIMESTAMP_EN
        nxt_w[1] = buf_ts[63:32];
        nxt_w[2] = buf_ts[31:0];
`endif
        if (buf_hdr) begin
            nxt_w[TS_WORDS + 1] = buf_options;
            nxt_w[TS_WORDS + 2] = buf_section;
            nxt_w[TS_WORDS + 3] = buf_x;
            nxt_w[TS_WORDS + 4] = buf_y;
            nxt_w[TS_WORDS + 5] = buf_z;
            nxt_w[TS_WORDS + 6] = buf_u;
            nxt_len             = 4'(7 + TS_WORDS);
        end else begin
            nxt_w[TS_WORDS + 1] = buf_x;
            nxt_w[TS_WORDS + 2] = buf_y;
            nxt_w[TS_WORDS + 3] = buf_z;
            nxt_w[TS_WORDS + 4] = buf_u;
            nxt_w[TS_WORDS + 5] = buf_src[0];
            nxt_w[TS_WORDS + 6] = buf_src[1];
            nxt_w[TS_WORDS + 7] = buf_src[2];
            nxt_w[TS_WORDS + 8] = buf_src[3];
            nxt_len             = 4'(9 + TS_WORDS);
        end
    end

    always_ff @(posedge a_clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            M_AXIS_tdata  <= '0;
            M_AXIS_tvalid <= 1'b0;
            M_AXIS_tlast  <= 1'b0;
            rem           <= '0;
            frames_sent   <= '0;
            for (int i = 0; i < MAXW; i++) begin
                frm[i] <= '0;
            end
        end else begin
            if (last_hs) begin
                frames_sent <= frames_sent + 32'd1;
            end

            if (xfer) begin
                // Load (from IDLE, or reload on the last handshake).
                state         <= SEND;
                M_AXIS_tdata  <= nxt_w[0];
                M_AXIS_tvalid <= 1'b1;
                M_AXIS_tlast  <= 1'b0;
                rem           <= nxt_len - 4'd1;
                for (int i = 0; i < MAXW - 1; i++) begin
                    frm[i] <= nxt_w[i + 1];
                end
                frm[MAXW - 1] <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        M_AXIS_tvalid <= 1'b0;
                        M_AXIS_tlast  <= 1'b0;
                    end
                    SEND: begin
                        if (hs) begin
                            if (M_AXIS_tlast) begin
                                state         <= IDLE;
                                M_AXIS_tvalid <= 1'b0;
                                M_AXIS_tlast  <= 1'b0;
                            end else begin
                                M_AXIS_tdata <= frm[0];
                                M_AXIS_tlast <= (rem == 4'd1);
                                rem          <= rem - 4'd1;
                                for (int i = 0; i < MAXW - 1; i++) begin
                                    frm[i] <= frm[i + 1];
                                end
                                frm[MAXW - 1] <= '0;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gvp_stream_packer.sv
// tb/tb_gvp_stream_packer.sv - scoreboard bench for gvp_stream_packer

module tb_gvp_stream_packer;

`ifdef GVP_PACK_TIMESTAMP_EN
    localparam bit TS = 1'b1;
`else
    localparam bit TS = 1'b0;
`endif

    logic        a_clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        sample_tick = 1'b0;
    logic [1:0]  store_data = 2'd0;
    logic        gvp_finished = 1'b0;
    logic [31:0] x = '0, y = '0, z = '0, u = '0;
    logic [31:0] options = '0, section = '0;
    logic [31:0] src0 = '0, src1 = '0, src2 = '0, src3 = '0;
    logic [31:0] M_AXIS_tdata;
    logic        M_AXIS_tvalid;
    logic        M_AXIS_tlast;
    logic        M_AXIS_tready = 1'b1;
    logic        busy;
    logic [15:0] overflow_count;
    logic [31:0] frames_sent;

    gvp_stream_packer #(.SEQ_W(8), .OVF_W(16)) dut (
        .a_clk          (a_clk),
        .reset          (reset),
        .enable         (enable),
        .sample_tick    (sample_tick),
        .store_data     (store_data),
        .gvp_finished   (gvp_finished),
        .x              (x),
        .y              (y),
        .z              (z),
        .u              (u),
        .options        (options),
        .section        (section),
        .src0           (src0),
        .src1           (src1),
        .src2           (src2),
        .src3           (src3),
        .M_AXIS_tdata   (M_AXIS_tdata),
        .M_AXIS_tvalid  (M_AXIS_tvalid),
        .M_AXIS_tlast   (M_AXIS_tlast),
        .M_AXIS_tready  (M_AXIS_tready),
        .busy           (busy),
        .overflow_count (overflow_count),
        .frames_sent    (frames_sent)
    );

    always #5 a_clk = ~a_clk;

    typedef struct {
        logic [31:0] d;
        logic        l;
        bit          dc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ts_words[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          hs_cnt = 0;
    int          exp_seq = 0;
    bit          holding = 0;
    logic [31:0] held;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake, checks hold stability.
    always @(negedge a_clk) begin
        if (reset) begin
            holding = 0;
        end else begin
            if (holding) begin
                chk("hold_valid", {31'd0, M_AXIS_tvalid}, 32'd1);
                chk("hold_data", M_AXIS_tdata, held);
            end
            holding = M_AXIS_tvalid && !M_AXIS_tready;
            held    = M_AXIS_tdata;
            if (M_AXIS_tvalid && M_AXIS_tready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", M_AXIS_tdata, 32'hFFFF_FFFF ^ M_AXIS_tdata);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.dc) begin
                        ts_words.push_back(M_AXIS_tdata);
                    end else begin
                        chk("word", M_AXIS_tdata, e.d);
                    end
                    chk("tlast", {31'd0, M_AXIS_tlast}, {31'd0, e.l});
                end
            end
        end
    end

    task automatic push_w(input logic [31:0] d, input logic l, input bit dc);
        exp_t e;
        e.d = d; e.l = l; e.dc = dc;
        exp_q.push_back(e);
    endtask

    function automatic logic [31:0] tag_of(input bit hdr, input int sq, input logic [31:0] sec);
        logic [7:0] s8;
        s8 = 8'(sq);
        return 32'hA000_0000 | (hdr ? 32'h0800_0000 : 32'h0400_0000) |
               (TS ? 32'h0100_0000 : 32'h0) | {8'h00, s8, sec[15:0]};
    endfunction

    task automatic push_frame(input bit hdr, input logic [31:0] sec, input logic [31:0] base);
        push_w(tag_of(hdr, exp_seq, sec), 1'b0, 0);
        exp_seq++;
        if (TS) begin
            push_w('0, 1'b0, 1);
            push_w('0, 1'b0, 1);
        end
        if (hdr) begin
            push_w(base + 9, 1'b0, 0);
            push_w(sec, 1'b0, 0);
            for (int i = 1; i <= 4; i++) push_w(base + 32'(i), (i == 4), 0);
        end else begin
            for (int i = 1; i <= 8; i++) push_w(base + 32'(i), (i == 8), 0);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge a_clk);
        #1;
    endtask

    // Presents one tick for one cycle; pushes the expected frame if the bench
    // expects it to be accepted.
    task automatic tick(input logic [1:0] sd, input logic [31:0] sec, input logic [31:0] base, input bit acc);
        x = base + 1; y = base + 2; z = base + 3; u = base + 4;
        src0 = base + 5; src1 = base + 6; src2 = base + 7; src3 = base + 8;
        options = base + 9; section = sec;
        store_data = sd; sample_tick = 1'b1;
        cyc(1);
        sample_tick = 1'b0; store_data = 2'd0;
        if (acc) push_frame(sd == 2'd2, sec, base);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(2);
        exp_q.delete();
        ts_words.delete();
        exp_seq = 0;
        reset = 1'b0;
        cyc(1);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 300) begin
            cyc(1);
            n++;
        end
        chk({name, "_drain_timeout"}, n, (n < 300) ? n : 0);
    endtask

    task automatic wait_hs(input int target);
        int n;
        n = 0;
        while (hs_cnt < target && n < 300) begin
            @(negedge a_clk);
            n++;
        end
        chk("hs_wait_timeout", n, (n < 300) ? n : 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int h0;
        // Reset values
        cyc(2);
        chk("rst_tvalid", {31'd0, M_AXIS_tvalid}, 32'd0);
        chk("rst_tlast", {31'd0, M_AXIS_tlast}, 32'd0);
        chk("rst_tdata", M_AXIS_tdata, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ovf", {16'd0, overflow_count}, 32'd0);
        chk("rst_frames", frames_sent, 32'd0);
        do_reset();

        // Single data frame with latency check
        M_AXIS_tready = 1'b1;
        tick(2'd1, 32'd3, 32'd0, 1);
        chk("lat_t1_tvalid", {31'd0, M_AXIS_tvalid}, 32'd0);
        chk("lat_t1_busy", {31'd0, busy}, 32'd1);
        cyc(1);
        chk("lat_t2_tvalid", {31'd0, M_AXIS_tvalid}, 32'd1);
        chk("lat_t2_tag", M_AXIS_tdata, TS ? 32'hA500_0003 : 32'hA400_0003);
        wait_idle("single");
        chk("single_frames", frames_sent, 32'd1);

        // Back-pressure and overflow
        do_reset();
        M_AXIS_tready = 1'b0;
        tick(2'd2, 32'h0010, 32'h100, 1);
        tick(2'd2, 32'h0011, 32'h200, 1);
        tick(2'd2, 32'h0012, 32'h300, 0);
        cyc(10);
        chk("bp_ovf", {16'd0, overflow_count}, 32'd1);
        chk("bp_tvalid", {31'd0, M_AXIS_tvalid}, 32'd1);
        chk("bp_tag0", M_AXIS_tdata, tag_of(1, 0, 32'h0010));
        chk("bp_busy", {31'd0, busy}, 32'd1);
        h0 = hs_cnt;
        M_AXIS_tready = 1'b1;
        cyc(TS ? 18 : 14);
        chk("bp_word_count", hs_cnt - h0, TS ? 32'd18 : 32'd14);
        chk("bp_tvalid_after", {31'd0, M_AXIS_tvalid}, 32'd0);
        chk("bp_frames", frames_sent, 32'd2);
        chk("bp_queue_empty", exp_q.size(), 32'd0);

        // Finished suppression
        do_reset();
        gvp_finished = 1'b1;
        cyc(1);
        tick(2'd2, 32'h0020, 32'h400, 1);
        for (int i = 0; i < 4; i++) tick(2'd2, 32'h0021, 32'h500, 0);
        wait_idle("fin");
        cyc(5);
        chk("fin_frames", frames_sent, 32'd1);
        chk("fin_ovf", {16'd0, overflow_count}, 32'd0);
        gvp_finished = 1'b0;
        cyc(1);
        tick(2'd2, 32'h0022, 32'h600, 1);
        wait_idle("fin2");
        chk("fin2_frames", frames_sent, 32'd2);

        // Reset mid-frame
        do_reset();
        tick(2'd1, 32'h0030, 32'h700, 1);
        wait_idle("mid0");
        h0 = hs_cnt;
        tick(2'd1, 32'h0031, 32'h800, 1);
        wait_hs(h0 + 3);
        @(posedge a_clk);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_tvalid", {31'd0, M_AXIS_tvalid}, 32'd0);
        chk("mid_frames", frames_sent, 32'd0);
        chk("mid_busy", {31'd0, busy}, 32'd0);
        do_reset();
        tick(2'd1, 32'h0032, 32'h900, 1);
        cyc(1);
        chk("mid_new_tag", M_AXIS_tdata, tag_of(0, 0, 32'h0032));
        wait_idle("mid1");
        chk("mid_new_frames", frames_sent, 32'd1);

        // Ignored inputs, and enable low not affecting a buffered frame
        do_reset();
        tick(2'd1, 32'h0040, 32'hA00, 1);
        enable = 1'b0;
        wait_idle("en");
        chk("en_inflight_frames", frames_sent, 32'd1);
        tick(2'd1, 32'h0041, 32'hB00, 0);
        tick(2'd2, 32'h0042, 32'hC00, 0);
        enable = 1'b1;
        tick(2'd3, 32'h0043, 32'hD00, 0);
        tick(2'd0, 32'h0044, 32'hE00, 0);
        cyc(20);
        chk("ign_frames", frames_sent, 32'd1);
        chk("ign_ovf", {16'd0, overflow_count}, 32'd0);
        chk("ign_busy", {31'd0, busy}, 32'd0);

`ifdef GVP_PACK_TIMESTAMP_EN
        // Timestamp spacing
        do_reset();
        tick(2'd1, 32'h0050, 32'hF00, 1);
        cyc(99);
        tick(2'd1, 32'h0051, 32'hF10, 1);
        wait_idle("ts");
        chk("ts_words", ts_words.size(), 32'd4);
        if (ts_words.size() == 4) begin
            logic [63:0] t0, t1;
            t0 = {ts_words[0], ts_words[1]};
            t1 = {ts_words[2], ts_words[3]};
            chk("ts_diff", 32'(t1 - t0), 32'd100);
        end
`endif

        chk("final_queue_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gvp_stream_packer.md
# gvp_stream_packer

Downstream companion of the GVP vector program core. Each GVP step is marked by a one-cycle tick. On ticks where the core requests a store, this block snapshots the vector position, section state and four data-source words into a typed, tagged frame. It then serializes the frame onto an AXI4-Stream master for the DMA/FIFO path. One snapshot buffer decouples GVP timing from stream back-pressure; overflows are counted, never stalled.

## Interface
- `SEQ_W`, 8: width of the frame sequence counter carried in the tag word.
- `OVF_W`, 16: width of the saturating overflow counter.
- `a_clk` in 1: single clock for all logic.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: capture enable; low ignores ticks, in-flight frames still complete.
- `sample_tick` in 1: one-cycle pulse per GVP step; `store_data` and the data inputs are valid in that cycle.
- `store_data` in 2: 2 = header frame, 1 = data frame, 0/3 = no capture.
- `gvp_finished` in 1: GVP end-of-program flag.
- `x`, `y`, `z`, `u` in 32 each: vector position.
- `options` in 32: section options.
- `section` in 32: section count.
- `src0`..`src3` in 32 each: data-source words.
- `M_AXIS_tdata` out 32: stream data.
- `M_AXIS_tvalid` out 1: stream valid.
- `M_AXIS_tlast` out 1: last word of frame.
- `M_AXIS_tready` in 1: stream ready.
- `busy` out 1: serializer active or snapshot buffer full.
- `overflow_count` out OVF_W: count of dropped captures.
- `frames_sent` out 32: count of completed frames.

## Operation
- **Capture condition:** `sample_tick && enable && store_data ∈ {1,2} && !fin_block`.
- **Snapshot buffer:** one frame deep, with a `buf_full` flag.
  - On capture with buffer free, latch all inputs, the type, and the current `seq`, then set `buf_full`.
  - The buffer also counts as free in any cycle in which it is being transferred to the serializer.
- **Overflow:** a capture while the buffer is full and not transferring is dropped. `overflow_count` increments and saturates at all-ones. The buffer contents are unchanged.
- **Sequence counter:** `seq` increments, wrapping, on every accepted capture.
- **Finished suppression:** on the rising edge of `gvp_finished`, set `fin_arm`.
  - The first header capture while `fin_arm` is set is accepted; it then sets `fin_block` and clears `fin_arm`.
  - `fin_block` clears when `gvp_finished` falls.
- **Serializer FSM:**
  - IDLE: if `buf_full`, load the frame shift registers, clear `buf_full`, go to SEND.
  - SEND: present word k. On `tvalid && tready`, advance k.
  - On the last word's handshake: if `buf_full`, reload and stay in SEND; else go to IDLE. In both cases increment `frames_sent`.
- **Tag word:** [31:28] = 4'hA; [27:26] = 2'b10 header / 2'b01 data; [25:24] = 0; [23:16] = seq (zero-extended/truncated to 8 bits); [15:0] = section[15:0].
- **Header frame (7 words):** tag, options, section, x, y, z, u.
- **Data frame (9 words):** tag, x, y, z, u, src0, src1, src2, src3.
- `tdata` is stable while `tvalid && !tready`.

## Timing
- **Reset values:** all counters, `seq`, `buf_full`, `fin_arm` and `fin_block` are 0; FSM is IDLE.
- **Output reset values:** `M_AXIS_tvalid`, `M_AXIS_tlast` and `busy` are 0, and `M_AXIS_tdata` is 0.
- **Latency:** a capture tick in cycle T sets `buf_full` at T+1. With the serializer idle, the tag word is on the bus with `tvalid` high at T+2.
- **Back-to-back frames:** zero bubble when the buffer is full at the last handshake; the next tag is presented in the following cycle.
- **Throughput:** with `tready` held high, a frame occupies exactly its word count in cycles.
- **Tick during transfer:** a tick in the same cycle the buffer transfers into the serializer is accepted, not an overflow.
- **Reset mid-frame:** `tvalid` deasserts immediately (asynchronously) and the partial frame is discarded. This is the one permitted AXI violation.
- **Enable mid-frame:** `enable` low has no effect on frames already buffered or in flight.

## Configuration
- `GVP_PACK_TIMESTAMP_EN` defined:
  - A 64-bit free-running `a_clk` counter, reset to 0, is sampled at capture.
  - Words ts[63:32] and ts[31:0] are inserted immediately after the tag.
  - Header becomes 9 words, data becomes 11 words, and tag bit [24] = 1.
- Undefined: no counter, frame lengths are as in Operation, and tag [24] = 0.

## Test plan
- **Single data frame:** reset, `tready` = 1, one tick with `store_data` = 1, x = 1, y = 2, z = 3, u = 4, src = 5..8, section = 3. Expect at T+2 the words 0xA4000003, 1, 2, 3, 4, 5, 6, 7, 8, with `tlast` on the 9th word; `frames_sent` = 1.
- **Back-pressure and overflow:** `tready` = 0, three header ticks. Expect frame 0 held stable in the serializer, frame 1 held in the buffer, `overflow_count` = 1. Release `tready`: exactly 14 words with tag seq 0 then 1, and no bubble between frames.
- **Finished suppression:** raise `gvp_finished` and issue 5 header ticks. Expect one header frame, then nothing. Lower `gvp_finished` and tick again: a new frame is emitted.
- **Reset mid-frame:** assert `reset` after the 3rd word handshake. Expect `tvalid` = 0 and counters = 0 the same cycle; after release, the next frame starts with seq = 0.
- **Ignored inputs:** `enable` = 0 with ticks, then `store_data` = 3 and 0 with `enable` = 1. Expect no frames and no overflow.
- **`GVP_PACK_TIMESTAMP_EN` build:** two ticks 100 cycles apart. Expect 11-word data frames and a timestamp difference of 100.
